alu_ctrl_fsm: RTL
=================

// Module: alu_ctrl_fsm
// PURPOSE
//  Multicycle control unit producing the ALU's control inputs (alu_op, alu_l) and the register-file/PC control.
//  Fetches 16-bit instructions through a req/ack port, decodes them, sequences FETCH->DECODE->EXEC and latches ALU flags.
//  Sits between instruction memory and the 4-bit datapath (regfile + alu); it is the instruction-side driver of the ALU interface.
// PARAMETERS
//  DATA_W  4   datapath / immediate width
//  PC_W    8   program counter and imem address width
//  INSTR_W 16  instruction width; fields: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb/imm4, [7:0] target
// PORTS
//  clk        in  1       single clock, rising edge
//  reset      in  1       synchronous, active-high
//  imem_req   out 1       fetch request
//  imem_addr  out PC_W    fetch address (= pc)
//  imem_ack   in  1       data valid; meaningful only while imem_req=1
//  imem_data  in  INSTR_W instruction word
//  rf_ra      out 4       regfile read address A (instr[7:4])
//  rf_rb      out 4       regfile read address B (instr[3:0])
//  rf_wa      out 4       regfile write address (instr[11:8])
//  rf_we      out 1       regfile write enable
//  rf_wsel    out 1       0 = write ALU result R, 1 = write imm
//  imm        out DATA_W  immediate (instr[3:0])
//  alu_op     out 2       ALUOp to ALU
//  alu_l      out 1       L (1 = logic class) to ALU
//  alu_zero, alu_carry, alu_sign  in 1 each   combinational ALU flags
//  flag_z, flag_c, flag_s         out 1 each  latched flags
//  halted     out 1       HALT executed
//  illegal    out 1       illegal-opcode trap (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=FETCH, pc=0, instr=0, flags=0, halted=0, illegal=0; during and in the cycle of reset all outputs are 0.
//  FETCH: imem_req=1, imem_addr=pc; on an edge with imem_ack=1, capture imem_data -> DECODE. No timeout; waits indefinitely.
//  ack with req=0 is ignored (covers a stale ack after reset).
//  DECODE (1 cycle): rf_ra/rf_rb/rf_wa/imm valid from the captured instr; no writes -> EXEC.
//  EXEC (1 cycle): alu_op/alu_l driven; rf_we pulses for exactly this cycle when applicable; pc and flags update at its closing edge -> FETCH.
//  Latency: 3 cycles per instruction + (ack wait cycles).
//  Opcodes:
//   0xxx ALU  {alu_l,alu_op}=opcode[2:0]: 000 ADD, 001 SUB, 010 PASSA, 011 NEGB, 100 AND, 101 OR, 110 XOR, 111 NOTA
//             rf_we=1, rf_wsel=0; flags <= {alu_zero,alu_carry,alu_sign}.
//   1000 LDI  rf_we=1, rf_wsel=1; flags unchanged.   1001 JMP  pc <= target.
//   1010 JZ / 1011 JC / 1100 JS  pc <= target if flag_z / flag_c / flag_s (the latched value, not the current ALU output), else pc+1.
//   1101 HALT -> HALT state: halted=1, imem_req=0; held until reset.   1110/1111 see CONFIGURATION.
//  Outside EXEC: alu_op=00, alu_l=0, rf_we=0.
//  pc+1 wraps 2^PC_W-1 -> 0 silently.
//  Reset mid-operation (any state, including FETCH with req pending) returns to the reset state at that edge;
//  a captured but unexecuted instr is discarded.
// CONFIGURATION
//  `ALU_CTRL_ILLEGAL_TRAP_EN defined: opcodes 1110/1111 enter TRAP state: illegal=1, imem_req=0, rf_we=0, pc frozen; held until reset.
//  Not defined: 1110/1111 execute as NOP (pc+1, no write, flags unchanged); illegal is tied 0.
// STRUCTURE
//  alu_ctrl_pkg:
//   - opcode localparams; state enum {FETCH,DECODE,EXEC,HALT,TRAP};
//   - {L,ALUOp} encodings shared with the ALU;
//   - instruction field offsets.
//  Sub-module alu_ctrl_decode: combinational opcode -> {is_alu, is_ldi, is_jmp, br_cond[1:0], is_halt, is_illegal, alu_l, alu_op}.
//  The FSM, pc and flags stay in alu_ctrl_fsm.
// TESTING
//  ack 0 wait cycles, SUB R1=R2-R3 (5-5): EXEC has alu_op=01, alu_l=0, rf_we=1, rf_wa=1; flag_z=1 after; pc 0->1 in 3 cycles.
//  imem_ack held low 4 cycles: imem_req stays 1, imem_addr constant, no state change; instruction completes 3 cycles after ack.
//  LDI R4,0xA then JZ 0x20 with flag_z=1: rf_wsel=1, imm=0xA; flags unchanged; pc=0x20 after JZ. Same with flag_z=0: pc=2.
//  pc=0xFF NOP -> pc=0x00; HALT -> halted=1, imem_req=0 for 10 cycles; reset -> halted=0, pc=0.
//  reset asserted while req pending, stale ack next cycle: ignored, pc=0, fetch restarts.
//  opcode 1111: with macro illegal=1, pc frozen; without it pc+1 and illegal=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle ALU control unit.
// Build option: ALU_CTRL_ILLEGAL_TRAP_EN (see alu_ctrl_fsm).
package alu_ctrl_pkg;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;
    localparam int IMM_LSB = 0;
    localparam int TGT_LSB = 0;

    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_JZ   = 4'b1010;
    localparam logic [3:0] OP_JC   = 4'b1011;
    localparam logic [3:0] OP_JS   = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1101;
    localparam logic [3:0] OP_ILL0 = 4'b1110;
    localparam logic [3:0] OP_ILL1 = 4'b1111;

    // {L,ALUOp} as seen by the ALU
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_PASSA = 3'b010;
    localparam logic [2:0] ALU_NEGB  = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;
    localparam logic [2:0] ALU_NOTA  = 3'b111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        HALT,
        TRAP
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_Z,
        BR_C,
        BR_S
    } br_cond_t;

    typedef struct packed {
        logic       is_alu;
        logic       is_ldi;
        logic       is_jmp;
        br_cond_t   br_cond;
        logic       is_halt;
        logic       is_illegal;
        logic       alu_l;
        logic [1:0] alu_op;
    } dec_t;

    // flags are ordered {z, c, s}
    function automatic logic br_taken(input br_cond_t c,
                                      input logic [2:0] flags);
        case (c)
            BR_Z:    return flags[2];
            BR_C:    return flags[1];
            BR_S:    return flags[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode classifier for the ALU control unit.
// Opcodes 1110/1111 flag is_illegal only with ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        if (!opcode[3]) begin
            dec.is_alu = 1'b1;
            {dec.alu_l, dec.alu_op} = opcode[2:0];
        end else begin
            unique case (opcode)
                OP_LDI:  dec.is_ldi  = 1'b1;
                OP_JMP:  dec.is_jmp  = 1'b1;
                OP_JZ:   dec.br_cond = BR_Z;
                OP_JC:   dec.br_cond = BR_C;
                OP_JS:   dec.br_cond = BR_S;
                OP_HALT: dec.is_halt = 1'b1;
                OP_ILL0, OP_ILL1: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    dec.is_illegal = 1'b1;
`endif
                end
                default: dec = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle FETCH/DECODE/EXEC controller driving the 4-bit ALU datapath.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to trap on opcodes 1110/1111.
module alu_ctrl_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         rf_ra,
    output logic [3:0]         rf_rb,
    output logic [3:0]         rf_wa,
    output logic               rf_we,
    output logic               rf_wsel,
    output logic [DATA_W-1:0]  imm,
    output logic [1:0]         alu_op,
    output logic               alu_l,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_sign,
    output logic               flag_z,
    output logic               flag_c,
    output logic               flag_s,
    output logic               halted,
    output logic               illegal
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [2:0]         flags_q, flags_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic               wsel_q, wsel_d;
    logic [1:0]         op_q, op_d;
    logic               l_q, l_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;

    dec_t               dec;
    logic [PC_W-1:0]    target;

    alu_ctrl_decode u_dec (
        .opcode (instr_q[OPC_LSB +: 4]),
        .dec    (dec)
    );

    assign target = instr_q[TGT_LSB +: PC_W];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        flags_d   = flags_q;
        req_d     = 1'b0;
        we_d      = 1'b0;
        wsel_d    = 1'b0;
        op_d      = 2'b00;
        l_d       = 1'b0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: begin
                req_d = 1'b1;
                // gating on req_q drops any ack left over from before reset
                if (req_q && imem_ack) begin
                    instr_d = imem_data;
                    state_d = DECODE;
                    req_d   = 1'b0;
                end
            end
            DECODE: begin
                state_d = EXEC;
                we_d    = dec.is_alu | dec.is_ldi;
                wsel_d  = dec.is_ldi;
                op_d    = dec.alu_op;
                l_d     = dec.alu_l;
            end
            EXEC: begin
                state_d = FETCH;
                req_d   = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                if (dec.is_alu)
                    flags_d = {alu_zero, alu_carry, alu_sign};
                if (dec.is_jmp || br_taken(dec.br_cond, flags_q))
                    pc_d = target;
                if (dec.is_halt) begin
                    state_d  = HALT;
                    req_d    = 1'b0;
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                end
                if (dec.is_illegal) begin
                    state_d   = TRAP;
                    req_d     = 1'b0;
                    illegal_d = 1'b1;
                    pc_d      = pc_q;
                end
            end
            HALT, TRAP: state_d = state_q;
            default:    state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            instr_q   <= '0;
            flags_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            wsel_q    <= 1'b0;
            op_q      <= 2'b00;
            l_q       <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            flags_q   <= flags_d;
            req_q     <= req_d;
            we_q      <= we_d;
            wsel_q    <= wsel_d;
            op_q      <= op_d;
            l_q       <= l_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign rf_ra     = instr_q[RA_LSB +: 4];
    assign rf_rb     = instr_q[RB_LSB +: 4];
    assign rf_wa     = instr_q[RD_LSB +: 4];
    assign imm       = instr_q[IMM_LSB +: DATA_W];
    assign rf_we     = we_q;
    assign rf_wsel   = wsel_q;
    assign alu_op    = op_q;
    assign alu_l     = l_q;
    assign flag_z    = flags_q[2];
    assign flag_c    = flags_q[1];
    assign flag_s    = flags_q[0];
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule
